// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage load/store initiator.
package mem_pkg;

  // Default widths and timeout of the memory interface
  localparam int MEM_ADDR_W  = 22;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_TAG_W   = 3;
  localparam int MEM_TIMEOUT = 255;

  // One queued load/store request
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_TAG_W-1:0]  tag;
  } req_t;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request queue. Pointers carry one extra wrap bit so that
// full and empty are told apart without an occupancy counter.
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type T          = req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  T                 store_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Refuse writes into a full queue even when a pop happens on the same edge
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head entry is presented combinationally so the consumer registers it on pop
  assign pop_data = store_q[rd_ptr_q[PTR_W-1:0]];

  // Next-pointer computation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  // Pointer registers; reset empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push_ok) store_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: queues requests, runs one req/ack
// memory transaction at a time, and returns a tagged one-cycle response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int TAG_W      = MEM_TAG_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Request layout sized by this instance's parameters
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } req_local_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  req_local_t        push_req;
  req_local_t        head_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TAG_W-1:0]  mem_tag_q, mem_tag_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic              resp_err_q, resp_err_d;

  assign push_req  = {req_we, req_addr, req_wdata, req_tag};
  assign req_ready = !fifo_full;

  mem_req_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (req_local_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and output decode of the transaction sequencer
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_tag_d    = mem_tag_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = head_req.we;
          mem_addr_d  = head_req.addr;
          mem_wdata_d = head_req.wdata;
          mem_tag_d   = head_req.tag;
          wait_cnt_d  = 8'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // An ack wins over a timeout that would expire on the same edge
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? '0 : mem_rdata;
          resp_tag_d   = mem_tag_q;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else if (wait_cnt_q + 8'd1 == TIMEOUT_CNT) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_tag_d   = mem_tag_q;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_tag_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_tag_q    <= mem_tag_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q   <= resp_tag_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small req/ack memory responder.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [21:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_tag;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_tag;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(22), .DATA_W(32), .TAG_W(3), .FIFO_DEPTH(4), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
    .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  tag;
    logic        err;
  } resp_exp_t;

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  resp_exp_t   resp_q[$];
  mem_exp_t    memx_q[$];
  logic [31:0] mem_model [logic [21:0]];
  int          checks   = 0;
  int          failures = 0;
  bit          ack_en   = 1'b1;
  bit          stray_ack = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory responder: zero-wait ack while enabled, plus an optional stray pulse
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_ack   = stray_ack | (ack_en & mem_req);
      mem_rdata = '0;
      if (ack_en && mem_req) begin
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else if (mem_model.exists(mem_addr)) mem_rdata = mem_model[mem_addr];
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid
  initial begin
    resp_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_valid_unexpected", resp_valid, 1'b0);
        end else begin
          e = resp_q.pop_front();
          $display("resp tag=%0d rdata=%08h err=%0d", resp_tag, resp_rdata, resp_err);
          chk("resp_tag", resp_tag, e.tag);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
        end
      end
    end
  end

  // Memory-side monitor: checks each new transaction as mem_req rises
  initial begin
    mem_exp_t m;
    logic     prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && !prev) begin
        if (memx_q.size() == 0) begin
          chk("mem_req_unexpected", mem_req, 1'b0);
        end else begin
          m = memx_q.pop_front();
          $display("mem  we=%0d addr=%06h wdata=%08h", mem_we, mem_addr, mem_wdata);
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      prev = mem_req;
    end
  end

  task automatic issue(bit we, logic [21:0] addr, logic [31:0] wdata, logic [2:0] tag,
                       logic [31:0] exp_rdata, bit exp_err);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_tag   = tag;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("push_wait_bound", req_ready, 1'b1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      resp_q.push_back('{rdata: exp_rdata, tag: tag, err: exp_err});
      memx_q.push_back('{we: we, addr: addr, wdata: wdata});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || memx_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_bound", resp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0;
    mem_model[22'h000010] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_tag", resp_tag, 3'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 22'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single load with minimum latency
    issue(1'b0, 22'h000010, 32'h0, 3'd5, 32'hDEADBEEF, 1'b0);
    idle();
    chk("lat_mem_req_n0", mem_req, 1'b0);
    @(negedge clk);
    chk("lat_mem_req_n1", mem_req, 1'b1);
    chk("lat_resp_n1", resp_valid, 1'b0);
    @(negedge clk);
    chk("lat_resp_n2", resp_valid, 1'b1);
    drain();

    // Store then load to the top address
    issue(1'b1, 22'h3FFFFF, 32'h12345678, 3'd1, 32'h0, 1'b0);
    issue(1'b0, 22'h3FFFFF, 32'h0, 3'd2, 32'h12345678, 1'b0);
    idle();
    drain();

    // Timeout then a normal request
    ack_en = 1'b0;
    issue(1'b0, 22'h000020, 32'h0, 3'd3, 32'h0, 1'b1);
    issue(1'b0, 22'h000010, 32'h0, 3'd4, 32'hDEADBEEF, 1'b0);
    idle();
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    cnt = 0;
    while (mem_req && n < 40) begin cnt++; n++; @(negedge clk); end
    chk("timeout_req_cycles", cnt, 4);
    ack_en = 1'b1;
    drain();

    // Fill the queue behind a stalled transaction
    ack_en = 1'b0;
    issue(1'b0, 22'h000100, 32'h0, 3'd0, 32'h0, 1'b1);
    idle();
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    for (int i = 1; i <= 4; i++) begin
      issue(1'b0, 22'(32'h100 + i), 32'h0, 3'(i), 32'h0, 1'b1);
      #1;
      if (i == 3) chk("fill_ready_after_3", req_ready, 1'b1);
      if (i == 4) chk("fill_ready_after_4", req_ready, 1'b0);
    end
    issue(1'b0, 22'h000105, 32'h0, 3'd5, 32'h0, 1'b1);
    #1;
    chk("fill_5th_after_pop_addr", mem_addr, 22'h000101);
    idle();
    drain();
    ack_en = 1'b1;

    // Stray ack while idle
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_mem_req", mem_req, 1'b0);
    chk("stray_req_ready", req_ready, 1'b1);
    chk("stray_resp_valid", resp_valid, 1'b0);
    issue(1'b0, 22'h000010, 32'h0, 3'd6, 32'hDEADBEEF, 1'b0);
    idle();
    drain();

    // Reset in the middle of a transaction with two requests queued
    ack_en = 1'b0;
    issue(1'b0, 22'h000200, 32'h0, 3'd1, 32'h0, 1'b1);
    issue(1'b0, 22'h000201, 32'h0, 3'd2, 32'h0, 1'b1);
    issue(1'b0, 22'h000202, 32'h0, 3'd3, 32'h0, 1'b1);
    idle();
    chk("midrst_mem_req_before", mem_req, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_mem_req_async", mem_req, 1'b0);
    resp_q.delete();
    memx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_mem_req", mem_req, 1'b0);
      chk("postrst_resp_valid", resp_valid, 1'b0);
    end
    chk("postrst_req_ready", req_ready, 1'b1);
    issue(1'b0, 22'h3FFFFF, 32'h0, 3'd7, 32'h12345678, 1'b0);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
